// File: rtl/j11bus_pkg.sv
// Shared types and constants for the DCJ11/DMA bus arbiter.
package j11bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [8:0] IOPAGE_DEF = 9'h1FF;
    localparam logic       ROUTE_MEM  = 1'b0;
    localparam logic       ROUTE_IO   = 1'b1;
    localparam int         REQ_W      = 43;

    typedef struct packed {
        logic        wr;
        logic        gp;
        logic        irq;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
    } req_t;

    // gp and irq cycles never touch memory, whatever their address.
    function automatic logic route_of(input req_t r, input logic [8:0] iopage);
        return (r.gp || r.irq || (r.addr[21:13] == iopage)) ? ROUTE_IO : ROUTE_MEM;
    endfunction

endpackage

// File: rtl/j11bus_hold.sv
// Per-master request latch: pend flag plus the request fields captured on the req pulse.
module j11bus_hold
    import j11bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             clr,
    input  logic [REQ_W-1:0] fields_i,
    output logic             pend,
    output logic [REQ_W-1:0] fields_o
);

    logic             pend_d, pend_q;
    logic [REQ_W-1:0] fld_d, fld_q;

    // A req while already pending is a protocol violation and is dropped.
    always_comb begin
        pend_d = pend_q;
        fld_d  = fld_q;
        if (req && !pend_q) begin
            pend_d = 1'b1;
            fld_d  = fields_i;
        end
        if (clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            fld_q  <= '0;
        end else begin
            pend_q <= pend_d;
            fld_q  <= fld_d;
        end
    end

    assign pend     = pend_q;
    assign fields_o = fld_q;

endmodule

// File: rtl/j11bus_arb.sv
// Round-robin arbiter and memory/I-O page decoder between the DCJ11 (m0) and a DMA engine (m1).
// state | meaning: IDLE wait for pend | ISSUE slave req pulse | WAIT slave ack or watchdog | DONE master ack pulse
module j11bus_arb
    import j11bus_pkg::*;
#(
    parameter int         TIMEOUT = 255,
    parameter logic [8:0] IOPAGE  = IOPAGE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic        m0_gp,
    input  logic        m0_irq,
    input  logic [21:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic [1:0]  m0_wstrb,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic        m1_gp,
    input  logic        m1_irq,
    input  logic [21:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic [1:0]  m1_wstrb,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic        s_wr,
    output logic        s_gp,
    output logic        s_irq,
    output logic [21:0] s_addr,
    output logic [15:0] s_wdata,
    output logic [1:0]  s_wstrb,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [15:0] io_rdata,
    input  logic        io_err,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic             last_q, owner_q, route_q;
    logic [WD_W-1:0]  wd_q;
    logic             mem_req_q, io_req_q;
    logic [1:0]       ack_q, grant_q;
    logic [15:0]      m0_rdata_q, m1_rdata_q;
    logic             m0_err_q, m1_err_q;
    req_t             s_q;

    logic [1:0]       pend;
    logic [REQ_W-1:0] fld0, fld1;
    logic             sel, sel_route;
    req_t             sel_fld;
    logic             slv_ack, slv_err;
    logic [15:0]      slv_rdata;

    j11bus_hold u_hold0 (
        .clk      (clk),
        .rst      (rst),
        .req      (m0_req),
        .clr      (ack_q[0]),
        .fields_i ({m0_wr, m0_gp, m0_irq, m0_addr, m0_wdata, m0_wstrb}),
        .pend     (pend[0]),
        .fields_o (fld0)
    );

    j11bus_hold u_hold1 (
        .clk      (clk),
        .rst      (rst),
        .req      (m1_req),
        .clr      (ack_q[1]),
        .fields_i ({m1_wr, m1_gp, m1_irq, m1_addr, m1_wdata, m1_wstrb}),
        .pend     (pend[1]),
        .fields_o (fld1)
    );

    // On a tie the master that did not win the last tie goes first.
    always_comb begin
        sel       = (&pend) ? ~last_q : pend[1];
        sel_fld   = req_t'(sel ? fld1 : fld0);
        sel_route = route_of(sel_fld, IOPAGE);
        slv_ack   = (route_q == ROUTE_IO) ? io_ack : mem_ack;
        slv_rdata = (route_q == ROUTE_IO) ? io_rdata : mem_rdata;
        slv_err   = (route_q == ROUTE_IO) && io_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            route_q    <= ROUTE_MEM;
            wd_q       <= '0;
            mem_req_q  <= 1'b0;
            io_req_q   <= 1'b0;
            ack_q      <= 2'b00;
            grant_q    <= 2'b00;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            s_q        <= '0;
        end else begin
            mem_req_q <= 1'b0;
            io_req_q  <= 1'b0;
            ack_q     <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|pend) begin
                        owner_q   <= sel;
                        route_q   <= sel_route;
                        s_q       <= sel_fld;
                        grant_q   <= sel ? 2'b10 : 2'b01;
                        mem_req_q <= (sel_route == ROUTE_MEM);
                        io_req_q  <= (sel_route == ROUTE_IO);
                        if (&pend) begin
                            last_q <= sel;
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A slave ack in the expiry cycle still wins over the watchdog.
                    if (slv_ack || (wd_q == WD_W'(TIMEOUT))) begin
                        if (owner_q) begin
                            m1_rdata_q <= slv_ack ? slv_rdata : 16'h0000;
                            m1_err_q   <= slv_ack ? slv_err : 1'b1;
                        end else begin
                            m0_rdata_q <= slv_ack ? slv_rdata : 16'h0000;
                            m0_err_q   <= slv_ack ? slv_err : 1'b1;
                        end
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= ST_DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_DONE: begin
                    grant_q <= 2'b00;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign s_wr     = s_q.wr;
    assign s_gp     = s_q.gp;
    assign s_irq    = s_q.irq;
    assign s_addr   = s_q.addr;
    assign s_wdata  = s_q.wdata;
    assign s_wstrb  = s_q.wstrb;
    assign mem_req  = mem_req_q;
    assign io_req   = io_req_q;
    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_j11bus_arb.sv
// Randomized and directed bench for j11bus_arb against a transaction-timing model.
module tb_j11bus_arb;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_wr = 0, m0_gp = 0, m0_irq = 0;
    logic [21:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic [1:0]  m0_wstrb = '0;
    logic        m0_ack, m0_err;
    logic [15:0] m0_rdata;
    logic        m1_req = 0, m1_wr = 0, m1_gp = 0, m1_irq = 0;
    logic [21:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic [1:0]  m1_wstrb = '0;
    logic        m1_ack, m1_err;
    logic [15:0] m1_rdata;
    logic        s_wr, s_gp, s_irq;
    logic [21:0] s_addr;
    logic [15:0] s_wdata;
    logic [1:0]  s_wstrb;
    logic        mem_req, io_req;
    logic        mem_ack = 0, io_ack = 0, io_err = 0;
    logic [15:0] mem_rdata = '0, io_rdata = '0;
    logic [1:0]  grant;
    logic        busy;

    j11bus_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_gp(m0_gp), .m0_irq(m0_irq), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_gp(m1_gp), .m1_irq(m1_irq), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_wr(s_wr), .s_gp(s_gp), .s_irq(s_irq), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata), .io_err(io_err),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic        gp;
        logic        irq;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
    } fld_t;

    function automatic bit is_io(input fld_t f);
        return f.gp || f.irq || (f.addr[21:13] == 9'h1FF);
    endfunction

    // Model: who owns the bus and the cycle numbers of its issue, wait start and completion.
    bit          md_valid = 0;
    bit          md_pend [2];
    fld_t        md_fld  [2];
    int          md_last, md_cur, md_issue, md_wait, md_fin, md_clr;
    bit          md_io;
    logic [15:0] md_rd [2];
    bit          md_er [2];
    bit          e_req;
    int          e_own;

    int          ack_cnt [2] = '{0, 0};
    int          ack_cyc [2] = '{0, 0};
    int          req_cyc [2] = '{0, 0};
    int          io_cnt = 0, mem_cnt = 0;
    logic [1:0]  gseq [$];
    fld_t        snap;

    always @(negedge clk) begin
        if (md_valid) begin
            e_req = (md_cur >= 0) && (cyc == md_issue);
            e_own = (md_cur >= 0) ? md_cur : 0;
            chk("mem_req", mem_req, e_req && !md_io);
            chk("io_req", io_req, e_req && md_io);
            chk("m0_ack", m0_ack, (md_cur == 0) && (cyc == md_fin));
            chk("m1_ack", m1_ack, (md_cur == 1) && (cyc == md_fin));
            chk("m0_rdata", m0_rdata, md_rd[0]);
            chk("m1_rdata", m1_rdata, md_rd[1]);
            chk("m0_err", m0_err, md_er[0]);
            chk("m1_err", m1_err, md_er[1]);
            chk("grant", grant, (md_cur < 0) ? 0 : ((md_cur == 0) ? 1 : 2));
            chk("busy", busy, md_cur >= 0);
            if (e_req) begin
                chk("s_fields", {s_wr, s_gp, s_irq, s_addr, s_wdata, s_wstrb}, md_fld[e_own]);
            end
        end
        if (io_req) io_cnt++;
        if (mem_req) mem_cnt++;
        if (mem_req || io_req) begin
            gseq.push_back(grant);
            snap = {s_wr, s_gp, s_irq, s_addr, s_wdata, s_wstrb};
        end
        if (m0_ack) begin ack_cnt[0]++; ack_cyc[0] = cyc; end
        if (m1_ack) begin ack_cnt[1]++; ack_cyc[1] = cyc; end

        if (rst) begin
            md_pend = '{0, 0};
            md_rd = '{16'h0, 16'h0};
            md_er = '{0, 0};
            md_last = 1; md_cur = -1; md_issue = -1; md_wait = -1; md_fin = -1; md_io = 0;
            md_valid = 1;
        end else if (md_valid) begin
            md_clr = -1;
            if (md_cur < 0) begin
                if (md_pend[0] && md_pend[1]) begin
                    md_cur = 1 - md_last;
                    md_last = md_cur;
                end else if (md_pend[0]) md_cur = 0;
                else if (md_pend[1]) md_cur = 1;
                if (md_cur >= 0) begin
                    md_issue = cyc + 1; md_wait = cyc + 2; md_fin = -1;
                    md_io = is_io(md_fld[md_cur]);
                end
            end else if (cyc == md_fin) begin
                md_clr = md_cur;
                md_cur = -1;
            end else if (md_fin < 0 && cyc >= md_wait) begin
                if (md_io ? io_ack : mem_ack) begin
                    md_rd[md_cur] = md_io ? io_rdata : mem_rdata;
                    md_er[md_cur] = md_io ? io_err : 1'b0;
                    md_fin = cyc + 1;
                end else if (cyc - md_wait == TIMEOUT) begin
                    md_rd[md_cur] = 16'h0;
                    md_er[md_cur] = 1;
                    md_fin = cyc + 1;
                end
            end
            if (m0_req && !md_pend[0]) begin
                md_pend[0] = 1;
                md_fld[0] = {m0_wr, m0_gp, m0_irq, m0_addr, m0_wdata, m0_wstrb};
            end
            if (m1_req && !md_pend[1]) begin
                md_pend[1] = 1;
                md_fld[1] = {m1_wr, m1_gp, m1_irq, m1_addr, m1_wdata, m1_wstrb};
            end
            if (md_clr >= 0) md_pend[md_clr] = 0;
        end
    end

    // Slave responder: resp_delay>0 fixed, 0 random, -1 never.
    int          resp_delay = 1;
    int          resp_ioerr = 0;
    bit          resp_fixed = 0;
    logic [15:0] resp_data = '0;
    bit          stray_rnd = 0;
    bit          stray_mem = 0;

    initial begin : responder
        int left;
        int d;
        bit sio;
        left = 0; sio = 0;
        forever begin
            @(negedge clk);
            if (rst) left = 0;
            else if (mem_req || io_req) begin
                sio = io_req;
                d = resp_delay;
                if (d == 0) d = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(1, 5));
                left = (d < 0) ? 0 : d;
            end
            @(posedge clk);
            #2;
            mem_ack = 0; io_ack = 0; io_err = 0;
            mem_rdata = 16'($urandom); io_rdata = 16'($urandom);
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    if (sio) begin
                        io_ack = 1;
                        io_err = (resp_ioerr == 2) ? 1'($urandom) : (resp_ioerr != 0);
                        if (resp_fixed) io_rdata = resp_data;
                    end else begin
                        mem_ack = 1;
                        if (resp_fixed) mem_rdata = resp_data;
                    end
                end
            end
            if (stray_rnd && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) mem_ack = 1;
                else begin io_ack = 1; io_err = 1'($urandom); end
            end
            if (stray_mem) mem_ack = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int n, input logic wr, input logic gp, input logic irq,
                         input logic [21:0] addr, input logic [15:0] wdata, input logic [1:0] wstrb);
        if (n == 0) begin
            m0_wr = wr; m0_gp = gp; m0_irq = irq; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end else begin
            m1_wr = wr; m1_gp = gp; m1_irq = irq; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end
    endtask

    task automatic set_rand(input int n);
        logic [21:0] a;
        a = 22'($urandom);
        if ($urandom_range(0, 3) == 0) a[21:13] = 9'h1FF;
        set_m(n, 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              a, 16'($urandom), 2'($urandom));
    endtask

    task automatic fire(input bit f0, input bit f1);
        m0_req = f0; m1_req = f1;
        if (f0) req_cyc[0] = cyc;
        if (f1) req_cyc[1] = cyc;
        tick();
        m0_req = 0; m1_req = 0;
    endtask

    task automatic wait_ack(input int n, input int target, input int budget);
        int b;
        b = budget;
        while (ack_cnt[n] < target && b > 0) begin
            tick();
            b--;
        end
        chk("ack_arrived", ack_cnt[n] >= target, 1);
    endtask

    int          b0, b1, bio, bmem, g0;
    logic [1:0]  exp_g [6];

    initial begin
        exp_g = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
        repeat (3) tick();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_reqs", {mem_req, io_req, m0_ack, m1_ack}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata, m0_err, m1_err}, 0);

        // CPU read of the I/O page, slave answers 3 cycles after io_req
        resp_delay = 3; resp_fixed = 1; resp_data = 16'o200;
        set_m(0, 0, 0, 0, 22'o17777560, 16'h0, 2'b11);
        b0 = ack_cnt[0]; bio = io_cnt;
        fire(1, 0);
        wait_ack(0, b0 + 1, 50);
        chk("cpu_io_req_once", io_cnt - bio, 1);
        chk("cpu_s_addr", snap.addr, 22'o17777560);
        chk("cpu_rdata", m0_rdata, 16'o200);
        chk("cpu_err", m0_err, 0);
        chk("cpu_latency", ack_cyc[0] - req_cyc[0], 6);

        // DMA write to memory, zero-wait
        resp_delay = 1;
        set_m(1, 1, 0, 0, 22'h001000, 16'hBEEF, 2'b01);
        b1 = ack_cnt[1]; bmem = mem_cnt;
        fire(0, 1);
        wait_ack(1, b1 + 1, 50);
        chk("dma_mem_req_once", mem_cnt - bmem, 1);
        chk("dma_s_wr", snap.wr, 1);
        chk("dma_s_wstrb", snap.wstrb, 2'b01);
        chk("dma_s_wdata", snap.wdata, 16'hBEEF);
        chk("dma_latency", ack_cyc[1] - req_cyc[1], 4);

        // simultaneous requests, three times
        resp_fixed = 0;
        g0 = gseq.size(); b0 = ack_cnt[0]; b1 = ack_cnt[1];
        for (int i = 0; i < 3; i++) begin
            set_rand(0); set_rand(1);
            fire(1, 1);
            wait_ack(0, b0 + i + 1, 100);
            wait_ack(1, b1 + i + 1, 100);
        end
        for (int i = 0; i < 6; i++) chk("tie_grant_order", gseq[g0 + i], exp_g[i]);
        chk("tie_no_loss", (ack_cnt[0] - b0) + (ack_cnt[1] - b1), 6);

        // unanswered memory read times out
        resp_delay = -1;
        set_m(0, 0, 0, 0, 22'h3E0000, 16'h0, 2'b11);
        b0 = ack_cnt[0];
        fire(1, 0);
        wait_ack(0, b0 + 1, TIMEOUT + 50);
        chk("to_err", m0_err, 1);
        chk("to_rdata", m0_rdata, 0);
        chk("to_latency", ack_cyc[0] - req_cyc[0], TIMEOUT + 4);

        // ack in the expiry cycle wins
        resp_delay = TIMEOUT + 1; resp_fixed = 1; resp_data = 16'h1234;
        fire(1, 0);
        wait_ack(0, b0 + 2, TIMEOUT + 50);
        chk("edge_err", m0_err, 0);
        chk("edge_rdata", m0_rdata, 16'h1234);
        chk("edge_latency", ack_cyc[0] - req_cyc[0], TIMEOUT + 4);

        // interrupt-acknowledge at address 0 goes to the I/O port
        resp_delay = 1; resp_ioerr = 1;
        set_m(0, 0, 0, 1, 22'h000000, 16'h0, 2'b11);
        b0 = ack_cnt[0]; bio = io_cnt;
        fire(1, 0);
        wait_ack(0, b0 + 1, 50);
        chk("irq_io_req", io_cnt - bio, 1);
        chk("irq_s_irq", snap.irq, 1);
        chk("irq_err", m0_err, 1);
        resp_ioerr = 0;

        // reset while waiting, late ack afterwards
        resp_delay = -1;
        set_m(0, 0, 0, 0, 22'h000100, 16'h0, 2'b11);
        b0 = ack_cnt[0];
        fire(1, 0);
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        bmem = mem_cnt;
        stray_mem = 1;
        tick();
        stray_mem = 0;
        repeat (3) tick();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_no_ack", ack_cnt[0] - b0, 0);
        chk("rst_mid_no_reissue", mem_cnt - bmem, 0);
        resp_delay = 1;
        set_m(1, 0, 0, 0, 22'h002000, 16'h0, 2'b11);
        b1 = ack_cnt[1];
        fire(0, 1);
        wait_ack(1, b1 + 1, 50);
        chk("rst_mid_dma_latency", ack_cyc[1] - req_cyc[1], 4);

        // randomized traffic, including protocol-violating repeat requests and stray acks
        resp_delay = 0; resp_fixed = 0; resp_ioerr = 2; stray_rnd = 1;
        for (int i = 0; i < 600; i++) begin
            bit f0, f1;
            f0 = ($urandom_range(0, 5) == 0);
            f1 = ($urandom_range(0, 5) == 0);
            if (f0) set_rand(0);
            if (f1) set_rand(1);
            fire(f0, f1);
        end
        b0 = 3000;
        while ((md_cur >= 0 || md_pend[0] || md_pend[1]) && b0 > 0) begin
            tick();
            b0--;
        end
        tick();
        chk("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/j11bus_arb.md
Name: j11bus_arb

Overview:
- Two-master bus arbiter and address decoder between the DCJ11 interface (master 0, CPU) and a DMA engine (master 1, e.g. disk/console controller).
- Latches one-cycle request pulses and grants the bus round-robin.
- Routes each transfer to the memory port or the I/O-page port, and returns ack/rdata/err to the requesting master.
- A watchdog turns unanswered transfers into bus errors (non-existent memory).

Parameters:
- TIMEOUT, 255: cycles in WAIT without slave ack before err is returned; counter width is clog2(TIMEOUT+1).
- IOPAGE, 9'h1FF: value of addr[21:13] selecting the I/O page (top 8 KB).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  one-cycle request pulse from CPU; fields valid that cycle and held until m0_ack
- m0_wr  in  1  1=write, 0=read
- m0_gp  in  1  general-purpose/console cycle, always routed to the I/O port
- m0_irq  in  1  interrupt-acknowledge cycle, always routed to the I/O port
- m0_addr  in  22  physical address
- m0_wdata  in  16  write data
- m0_wstrb  in  2  byte strobes (bit1 = high byte)
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  16  read data, valid with m0_ack
- m0_err  out  1  bus error, valid with m0_ack
- m1_req, m1_wr, m1_gp, m1_irq, m1_addr, m1_wdata, m1_wstrb, m1_ack, m1_rdata, m1_err: same set for the DMA master
- s_wr  out  1  shared slave write flag
- s_gp  out  1  shared slave gp flag
- s_irq  out  1  shared slave irq flag
- s_addr  out  22  shared slave address
- s_wdata  out  16  shared slave write data
- s_wstrb  out  2  shared slave byte strobes
- mem_req  out  1  one-cycle request pulse to memory
- mem_ack  in  1  memory completion
- mem_rdata  in  16  memory read data
- io_req  out  1  one-cycle request pulse to the I/O page
- io_ack  in  1  I/O completion
- io_rdata  in  16  I/O read data
- io_err  in  1  I/O error, valid with io_ack
- grant  out  2  one-hot owner of the current transfer (debug)
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, pend[1:0]=0, last=1 (CPU wins the first tie), state=IDLE, s_* fields 0.
- Request capture: an mN_req pulse sets pend[N] and latches that master's fields into holding registers. A req while pend[N] is set is a protocol violation and is ignored. pend[N] clears on the cycle mN_ack is driven.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no pend: stay in IDLE.
- IDLE, pend set: pick the owner.
  - Only one pending: that master.
  - Both pending: the master that is not `last`. Set last=owner.
  - Requests are sampled from pend, so a req pulse reaches ISSUE no earlier than 2 cycles later.
- ISSUE: drive s_* from the owner's holding registers (s_* held until leaving DONE). Pulse exactly one of mem_req/io_req for one cycle.
  - io if gp or irq, or addr[21:13]==IOPAGE; mem otherwise.
  - Clear the watchdog. Go to WAIT.
- WAIT: consider only the ack of the selected slave; an ack from the other slave is ignored.
  - On ack: capture rdata (and io_err for io; err=0 for mem), go to DONE.
  - Otherwise, on watchdog==TIMEOUT: rdata=0, err=1, go to DONE.
  - Ack in the same cycle as watchdog expiry: the ack wins, err from the slave.
- DONE: one-cycle pulse of mN_ack with mN_rdata/mN_err for the owner; clear pend[owner]; go to IDLE.
  - mN_rdata/mN_err hold their value until the next ack to that master.
  - Back-to-back: the other master's pending request issues 2 cycles after DONE (DONE→IDLE→ISSUE).
- Minimum latency: req at cycle t, ISSUE at t+2; 0-wait slave ack at t+3; mN_ack at t+4.
- A new req from the owner while in flight is ignored; the other master's req is latched and served next.
- Reset mid-transfer: return to IDLE, drop all pend, generate no mN_ack. Late slave acks arriving in IDLE are ignored.
- No reordering: each master has at most one outstanding transfer.

Decomposition:
- Shared package j11bus_pkg:
  - FSM state encoding.
  - IOPAGE default.
  - Route-select constant (ROUTE_MEM=0, ROUTE_IO=1).
  - Request-field bundle width: 1+1+1+22+16+2 = 43 bits.
- One natural sub-module j11bus_hold, instantiated twice: the per-master request latch (pend flag plus field register, set on req, clear on ack).

Test Plan:
- CPU read 22'o17777560 (I/O page), io_ack 3 cycles after io_req with io_rdata=16'o200 → io_req pulsed once, s_addr=22'o17777560, m0_ack with m0_rdata=16'o200 and m0_err=0.
- DMA write 22'h001000, wdata=16'hBEEF, wstrb=2'b01, mem_ack immediate → mem_req, s_wr=1, s_wstrb=01; m1_ack exactly 4 cycles after m1_req.
- m0_req and m1_req in the same cycle, repeated 3 times → grant order CPU, DMA, DMA, CPU, CPU, DMA (round-robin from reset last=1); no request lost.
- CPU read 22'h3E0000 with no slave ack → m0_ack with m0_err=1 and m0_rdata=0 after TIMEOUT+1 WAIT cycles; mem_ack at exactly watchdog==TIMEOUT → err=0.
- m0_irq=1 with address 22'h000000 → routed to io_req with s_irq=1; io_err=1 is returned as m0_err=1.
- rst asserted in WAIT, then mem_ack after reset → no m0_ack, busy=0, pend cleared; a subsequent m1_req is served normally.
